fp_exec_unit: RTL



---
 rtl/fp_pkg.sv | 29 ++
 rtl/fp_arith_core.sv | 155 +++++++++++++++
 rtl/fp_exec_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the RV32F execute unit: op encodings, flag indices and latencies.
package fp_pkg;

   localparam logic [1:0] FP_ADD = 2'b00;
   localparam logic [1:0] FP_SUB = 2'b01;
   localparam logic [1:0] FP_MUL = 2'b10;
   localparam logic [1:0] FP_DIV = 2'b11;

   localparam logic [31:0] CANON_NAN = 32'h7FC00000;

   // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
   localparam int unsigned FLAG_NX = 0;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_NV = 4;

   localparam int unsigned LAT_ADD_DEF = 3;
   localparam int unsigned LAT_MUL_DEF = 4;
   localparam int unsigned LAT_DIV_DEF = 6;

   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } fpState_t;

endpackage

// File: rtl/fp_arith_core.sv
// Combinational single-precision add/sub/mul/div: truncating, flush-to-zero on input and output.
module fp_arith_core
   import fp_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic [4:0]  flags
);

   logic        signA, signB, zeroA, zeroB, infA, infB, nanA, nanB, sNan, effSub;
   logic [7:0]  expA, expB;
   logic [23:0] manA, manB;

   assign expA   = a[30:23];
   assign expB   = b[30:23];
   assign manA   = {1'b1, a[22:0]};
   assign manB   = {1'b1, b[22:0]};
   assign signA  = a[31];
   assign signB  = b[31] ^ (op == FP_SUB);
   assign zeroA  = (expA == 8'd0);
   assign zeroB  = (expB == 8'd0);
   assign infA   = (expA == 8'hFF) && (a[22:0] == 23'd0);
   assign infB   = (expB == 8'hFF) && (b[22:0] == 23'd0);
   assign nanA   = (expA == 8'hFF) && (a[22:0] != 23'd0);
   assign nanB   = (expB == 8'hFF) && (b[22:0] != 23'd0);
   assign sNan   = (nanA && !a[22]) || (nanB && !b[22]);
   assign effSub = signA ^ signB;

   logic               swap, addSign, normSign, remNz;
   logic [7:0]         bigExp, diff;
   logic [51:0]        alignX, alignY, sum, norm;
   logic [50:0]        shifted;
   logic [47:0]        prod;
   logic [25:0]        quo;
   logic [24:0]        rem;
   logic [5:0]         lead;
   logic signed [10:0] expBase, expOut;
   logic [31:0]        normRes;
   logic [4:0]         normFlags;

   always_comb begin
      // Addition: larger magnitude in alignX, leading one at bit 50
      swap    = {expB, manB} > {expA, manA};
      bigExp  = swap ? expB : expA;
      diff    = swap ? (expB - expA) : (expA - expB);
      alignX  = {1'b0, (swap ? manB : manA), 27'd0};
      alignY  = {1'b0, (swap ? manA : manB), 27'd0} >> ((diff > 8'd27) ? 8'd27 : diff);
      sum     = effSub ? (alignX - alignY) : (alignX + alignY);
      addSign = swap ? signB : signA;

      prod = 48'(manA) * 48'(manB);

      // Restoring division: 26 quotient bits, remainder feeds sticky
      rem = {1'b0, manA};
      quo = '0;
      for (int i = 25; i >= 0; i--) begin
         if (rem >= {1'b0, manB}) begin
            quo[i] = 1'b1;
            rem    = rem - {1'b0, manB};
         end
         rem = {rem[23:0], 1'b0};
      end
      remNz = (rem != 25'd0);

      case (op)
         FP_MUL: begin
            norm     = {prod, 4'd0};
            expBase  = 11'(expA) + 11'(expB) - 11'd127;
            normSign = signA ^ signB;
         end
         FP_DIV: begin
            norm     = {1'b0, quo, 24'd0, remNz};
            expBase  = 11'(expA) - 11'(expB) + 11'd127;
            normSign = signA ^ signB;
         end
         default: begin
            norm     = sum;
            expBase  = 11'(bigExp);
            normSign = addSign;
         end
      endcase

      lead = 6'd0;
      for (int i = 0; i < 52; i++) begin
         if (norm[i]) lead = 6'(i);
      end
      shifted = 51'(norm << (6'd51 - lead));
      expOut  = expBase + 11'(lead) - 11'd50;

      normFlags = '0;
      if (expOut >= 11'sd255) begin
         normRes            = {normSign, 8'hFF, 23'd0};
         normFlags[FLAG_OF] = 1'b1;
         normFlags[FLAG_NX] = 1'b1;
      end else if (expOut <= 11'sd0) begin
         normRes            = {normSign, 31'd0};
         normFlags[FLAG_UF] = 1'b1;
         normFlags[FLAG_NX] = 1'b1;
      end else begin
         normRes            = {normSign, expOut[7:0], shifted[50:28]};
         normFlags[FLAG_NX] = |shifted[27:0];
      end

      result = normRes;
      flags  = normFlags;
      if (nanA || nanB) begin
         result         = CANON_NAN;
         flags          = '0;
         flags[FLAG_NV] = sNan;
      end else begin
         case (op)
            FP_MUL: begin
               if ((infA && zeroB) || (zeroA && infB)) begin
                  result = CANON_NAN; flags = '0; flags[FLAG_NV] = 1'b1;
               end else if (infA || infB) begin
                  result = {signA ^ signB, 8'hFF, 23'd0}; flags = '0;
               end else if (zeroA || zeroB) begin
                  result = {signA ^ signB, 31'd0}; flags = '0;
               end
            end
            FP_DIV: begin
               if ((infA && infB) || (zeroA && zeroB)) begin
                  result = CANON_NAN; flags = '0; flags[FLAG_NV] = 1'b1;
               end else if (infA) begin
                  result = {signA ^ signB, 8'hFF, 23'd0}; flags = '0;
               end else if (infB || zeroA) begin
                  result = {signA ^ signB, 31'd0}; flags = '0;
               end else if (zeroB) begin
                  result = {signA ^ signB, 8'hFF, 23'd0}; flags = '0; flags[FLAG_DZ] = 1'b1;
               end
            end
            default: begin
               if (infA && infB && effSub) begin
                  result = CANON_NAN; flags = '0; flags[FLAG_NV] = 1'b1;
               end else if (infA) begin
                  result = {signA, 8'hFF, 23'd0}; flags = '0;
               end else if (infB) begin
                  result = {signB, 8'hFF, 23'd0}; flags = '0;
               end else if (zeroA && zeroB) begin
                  result = {signA & signB, 31'd0}; flags = '0;
               end else if (zeroA) begin
                  result = {signB, b[30:0]}; flags = '0;
               end else if (zeroB) begin
                  result = a; flags = '0;
               end else if (sum == 52'd0) begin
                  result = 32'd0; flags = '0;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/fp_exec_unit.sv
// EX-stage FP unit: captures an op, sequences its fixed latency, and returns a registered result.
module fp_exec_unit
   import fp_pkg::*;
#(
   parameter int unsigned LAT_ADD = LAT_ADD_DEF,
   parameter int unsigned LAT_MUL = LAT_MUL_DEF,
   parameter int unsigned LAT_DIV = LAT_DIV_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [4:0]  rd_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        result_valid_o,
   output logic [31:0] result_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  flags_o
);

   fpState_t         state, stateNext;
   logic [CNT_W-1:0] count, countNext;
   logic             busyNext, validQ, validNext, capture, loadOut;
   logic [1:0]       opQ, coreOp;
   logic [31:0]      aQ, bQ, coreA, coreB, coreResult;
   logic [4:0]       rdQ, coreRd, coreFlags;

   function automatic logic [CNT_W-1:0] loadCount(input logic [1:0] op);
      case (op)
         FP_MUL:  loadCount = CNT_W'(LAT_MUL - 1);
         FP_DIV:  loadCount = CNT_W'(LAT_DIV - 1);
         default: loadCount = CNT_W'(LAT_ADD - 1);
      endcase
   endfunction

   // The core reads live inputs on the accept cycle so a latency of 2 still works
   assign coreOp = (state == IDLE) ? op_i : opQ;
   assign coreA  = (state == IDLE) ? a_i  : aQ;
   assign coreB  = (state == IDLE) ? b_i  : bQ;
   assign coreRd = (state == IDLE) ? rd_i : rdQ;

   fp_arith_core core (
      .op     (coreOp),
      .a      (coreA),
      .b      (coreB),
      .result (coreResult),
      .flags  (coreFlags)
   );

   assign result_valid_o = validQ & ~flush_i;

   always_comb begin
      stateNext = state;
      countNext = count;
      busyNext  = busy_o;
      validNext = 1'b0;
      capture   = 1'b0;
      loadOut   = 1'b0;
      case (state)
         IDLE: begin
            if (start_i && !flush_i) begin
               capture   = 1'b1;
               stateNext = BUSY;
               countNext = loadCount(op_i);
               busyNext  = 1'b1;
               if (loadCount(op_i) == CNT_W'(1)) begin
                  validNext = 1'b1;
                  loadOut   = 1'b1;
               end
            end
         end
         BUSY: begin
            if (flush_i || (count == CNT_W'(1))) begin
               stateNext = IDLE;
               countNext = '0;
               busyNext  = 1'b0;
            end else begin
               countNext = count - CNT_W'(1);
               // Result lands on the edge into the counter==1 cycle
               if (count == CNT_W'(2)) begin
                  validNext = 1'b1;
                  loadOut   = 1'b1;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         busy_o <= 1'b0;
         validQ <= 1'b0;
      end else begin
         state  <= stateNext;
         count  <= countNext;
         busy_o <= busyNext;
         validQ <= validNext;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opQ      <= '0;
         aQ       <= '0;
         bQ       <= '0;
         rdQ      <= '0;
         result_o <= '0;
         rd_o     <= '0;
         flags_o  <= '0;
      end else begin
         if (capture) begin
            opQ <= op_i;
            aQ  <= a_i;
            bQ  <= b_i;
            rdQ <= rd_i;
         end
         if (loadOut) begin
            result_o <= coreResult;
            rd_o     <= coreRd;
            flags_o  <= coreFlags;
         end
      end
   end

endmodule
